// File: rtl/boot_controller.sv
// -----------------------------------------------------------------------------
// boot_controller
//
// Boot/run sequencer for the 8-bit CPU. After reset, or after a reboot request,
// it holds the CPU in reset and restarts the bootloader. It enables the
// bootloader's write strobes and counts 16 RAM writes. It then allows one
// settle cycle and releases the CPU. A reboot request while the CPU runs waits
// for an instruction boundary, with a bounded drain window, before the next boot.
//
// Ports:
//   clk                 system clock
//   rst                 asynchronous, active-high reset
//   program_select      raw program switches (sampled only in BOOT_RST)
//   reboot_btn          asynchronous level reboot request, active-high
//   bootload_ram        bootloader RAM-write strobe (observed)
//   cpu_instr_boundary  high in the CPU's final microstep
//   cpu_halted          CPU has executed HALT
//   bl_rst              bootloader reset
//   enable_bootload     bootloader output enable
//   bl_program_select   select latched at boot, driven to the bootloader
//   cpu_rst             CPU reset
//   cpu_clk_en          CPU clock enable
//   boot_error          sticky boot-failure flag
//   state_dbg           current state encoding, for LEDs
// -----------------------------------------------------------------------------
module boot_controller #(
   parameter int NUM_PROGRAMS  = 4,
   parameter int SYNC_STAGES   = 2,   // minimum 2
   parameter int BOOT_TIMEOUT  = 48,  // must exceed the nominal 32-cycle load
   parameter int DRAIN_TIMEOUT = 8,
   localparam int SEL_W = (NUM_PROGRAMS > 1) ? $clog2(NUM_PROGRAMS) : 1,
   localparam int TMR_W = $clog2(BOOT_TIMEOUT + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SEL_W-1:0] program_select,
   input  logic             reboot_btn,
   input  logic             bootload_ram,
   input  logic             cpu_instr_boundary,
   input  logic             cpu_halted,
   output logic             bl_rst,
   output logic             enable_bootload,
   output logic [SEL_W-1:0] bl_program_select,
   output logic             cpu_rst,
   output logic             cpu_clk_en,
   output logic             boot_error,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      ST_BOOT_RST = 3'd0,
      ST_BOOTING  = 3'd1,
      ST_SETTLE   = 3'd2,
      ST_RUN      = 3'd3,
      ST_DRAIN    = 3'd4,
      ST_HALTED   = 3'd5,
      ST_ERROR    = 3'd6
   } state_t;

   localparam logic [4:0] WR_DONE = 5'd16;

   state_t                 state_q, state_d;
   logic [4:0]             wr_cnt_q, wr_cnt_d;
   logic [TMR_W-1:0]       timer_q, timer_d;
   logic                   boot_error_q, boot_error_d;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   btn_prev_q, btn_prev_d;
   logic                   bl_rst_q, bl_rst_d;
   logic                   cpu_rst_q, cpu_rst_d;
   logic                   cpu_clk_en_q, cpu_clk_en_d;
   logic                   enable_bootload_q, enable_bootload_d;

   logic                   btn_sync;
   logic                   reboot_evt;
   logic [TMR_W-1:0]       timer_inc;
   logic [4:0]             wr_cnt_inc;

   // A reboot event is a rising edge of the synchronized button. Holding the
   // button yields one event, and events in states that ignore them are lost.
   assign btn_sync   = sync_q[SYNC_STAGES-1];
   assign reboot_evt = btn_sync & ~btn_prev_q;

   // Both counters saturate rather than wrap.
   assign timer_inc  = (timer_q == {TMR_W{1'b1}}) ? timer_q : timer_q + TMR_W'(1);
   assign wr_cnt_inc = (wr_cnt_q == WR_DONE) ? wr_cnt_q : wr_cnt_q + 5'd1;

   // NOTE: every variable gets a default at the top of the block, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      wr_cnt_d     = wr_cnt_q;
      timer_d      = timer_q;
      boot_error_d = boot_error_q;
      sel_d        = sel_q;
      sync_d       = {sync_q[SYNC_STAGES-2:0], reboot_btn};
      btn_prev_d   = btn_sync;

      unique case (state_q)
         ST_BOOT_RST: begin
            sel_d    = program_select;
            wr_cnt_d = '0;
            timer_d  = '0;
            state_d  = ST_BOOTING;
         end
         ST_BOOTING: begin
            timer_d = timer_inc;
            if (bootload_ram) wr_cnt_d = wr_cnt_inc;
            // The 16th write wins over a timeout that expires in the same cycle.
            if (wr_cnt_d == WR_DONE)                      state_d = ST_SETTLE;
            else if (timer_inc >= TMR_W'(BOOT_TIMEOUT))   state_d = ST_ERROR;
         end
         ST_SETTLE: state_d = ST_RUN;
         ST_RUN: begin
            if (reboot_evt) begin
               state_d = ST_DRAIN;
               timer_d = '0;
            end else if (cpu_halted) begin
               state_d = ST_HALTED;
            end
         end
         ST_DRAIN: begin
            timer_d = timer_inc;
            if (cpu_instr_boundary || timer_inc >= TMR_W'(DRAIN_TIMEOUT)) state_d = ST_BOOT_RST;
         end
         ST_HALTED: begin
            if (reboot_evt) state_d = ST_BOOT_RST;
         end
         ST_ERROR: begin
            if (reboot_evt) begin
               boot_error_d = 1'b0;
               state_d      = ST_BOOT_RST;
            end
         end
         default: state_d = ST_BOOT_RST;
      endcase

      if (state_d == ST_ERROR) boot_error_d = 1'b1;

      // NOTE: outputs are decoded from the next state and then registered, so they stay glitch-free and in step with state_q.
      bl_rst_d          = (state_d == ST_BOOT_RST);
      enable_bootload_d = (state_d == ST_BOOTING);
      cpu_clk_en_d      = (state_d == ST_RUN) || (state_d == ST_DRAIN);
      cpu_rst_d         = !((state_d == ST_RUN) || (state_d == ST_DRAIN) || (state_d == ST_HALTED));
   end

   // NOTE: every flop, including the synchronizer, has a defined reset value, so state is known the moment rst is asserted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q           <= ST_BOOT_RST;
         wr_cnt_q          <= '0;
         timer_q           <= '0;
         boot_error_q      <= 1'b0;
         sel_q             <= '0;
         sync_q            <= '0;
         btn_prev_q        <= 1'b0;
         bl_rst_q          <= 1'b1;
         cpu_rst_q         <= 1'b1;
         cpu_clk_en_q      <= 1'b0;
         enable_bootload_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make all flops update together from the same pre-edge values.
         state_q           <= state_d;
         wr_cnt_q          <= wr_cnt_d;
         timer_q           <= timer_d;
         boot_error_q      <= boot_error_d;
         sel_q             <= sel_d;
         sync_q            <= sync_d;
         btn_prev_q        <= btn_prev_d;
         bl_rst_q          <= bl_rst_d;
         cpu_rst_q         <= cpu_rst_d;
         cpu_clk_en_q      <= cpu_clk_en_d;
         enable_bootload_q <= enable_bootload_d;
      end
   end

   assign bl_rst            = bl_rst_q;
   assign enable_bootload   = enable_bootload_q;
   assign bl_program_select = sel_q;
   assign cpu_rst           = cpu_rst_q;
   assign cpu_clk_en        = cpu_clk_en_q;
   assign boot_error        = boot_error_q;
   assign state_dbg         = state_q;

endmodule
